// File: rtl/pipelined_carry_select_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder.
interface pipelined_carry_select_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, S, cout, ovf, out_valid
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, S, cout, ovf, out_valid
  );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice per stage,
// each slice precomputes both carry-in cases and picks one with the carry
// registered by the previous stage. Valid/ready flow control with bubble
// collapsing; the last stage registers drive the outputs directly.
module pipelined_carry_select_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  pipelined_carry_select_adder_if.slave bus
);
  localparam int unsigned NBLK = (BLOCK >= 1) ? WIDTH / BLOCK : 1;

  if (BLOCK < 1 || BLOCK > WIDTH || ((BLOCK >= 1) ? (WIDTH % BLOCK) : 0) != 0) begin : g_cfg_err
    $error("pipelined_carry_select_adder: WIDTH must be a multiple of BLOCK, 1 <= BLOCK <= WIDTH");
  end

  logic [NBLK-1:0] vld;
  logic [NBLK-1:0] en;  // stage k register may load this cycle

  // A stage can load when it is empty or its content moves on downstream.
  always_comb begin
    en = '0;
    en[NBLK-1] = !vld[NBLK-1] || bus.out_ready;
    for (int k = int'(NBLK) - 2; k >= 0; k--) begin
      en[k] = !vld[k] || en[k+1];
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    // Operand bits still to be summed when entering this stage.
    localparam int unsigned IW = WIDTH - k * BLOCK;
    // Result bits completed after this stage.
    localparam int unsigned LW = (k + 1) * BLOCK;

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [BLOCK:0]   s0;
    logic [BLOCK:0]   s1;
    logic [BLOCK-1:0] blk_sum;
    logic             c_out;
    logic [LW-1:0]    sum_nxt;
    logic             vld_q;
    logic             c_q;
    logic [LW-1:0]    sum_q;

    if (k == 0) begin : g_head
      // Subtract is A + ~B + 1, with cin acting as an active-high borrow.
      assign a_in    = bus.A;
      assign b_in    = bus.B ^ {WIDTH{bus.sub}};
      assign c_in    = bus.cin ^ bus.sub;
      assign v_in    = bus.in_valid;
      assign sum_nxt = blk_sum;
    end else begin : g_body
      assign a_in    = g_stage[k-1].g_pass.a_q;
      assign b_in    = g_stage[k-1].g_pass.b_q;
      assign c_in    = g_stage[k-1].c_q;
      assign v_in    = g_stage[k-1].vld_q;
      assign sum_nxt = {blk_sum, g_stage[k-1].sum_q};
    end

    // Both candidate block sums, then select with the incoming carry.
    always_comb begin
      s0      = {1'b0, a_in[BLOCK-1:0]} + {1'b0, b_in[BLOCK-1:0]};
      s1      = {1'b0, a_in[BLOCK-1:0]} + {1'b0, b_in[BLOCK-1:0]} + {{BLOCK{1'b0}}, 1'b1};
      blk_sum = c_in ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
      c_out   = c_in ? s1[BLOCK] : s0[BLOCK];
    end

    // Stage valid, completed low sum bits and outgoing carry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en[k]) begin
        vld_q <= v_in;
        c_q   <= c_out;
        sum_q <= sum_nxt;
      end
    end

    assign vld[k] = vld_q;

    if (k < NBLK - 1) begin : g_pass
      logic [IW-BLOCK-1:0] a_q;
      logic [IW-BLOCK-1:0] b_q;

      // Carry the unsummed upper operand bits forward.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en[k]) begin
          a_q <= a_in[IW-1:BLOCK];
          b_q <= b_in[IW-1:BLOCK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Overflow: effective operand MSBs agree but the result MSB does not.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en[k]) begin
          ovf_q <= (a_in[IW-1] == b_in[IW-1]) && (blk_sum[BLOCK-1] != a_in[IW-1]);
        end
      end
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = g_stage[NBLK-1].vld_q;
  assign bus.S         = g_stage[NBLK-1].sum_q;
  assign bus.cout      = g_stage[NBLK-1].c_q;
  assign bus.ovf       = g_stage[NBLK-1].g_last.ovf_q;

endmodule

// File: doc/pipelined_carry_select_adder.md
PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter BLOCK, default 4, bits per carry-select block; NBLK = WIDTH/BLOCK pipeline stages.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operands present on A, B, cin, sub.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 B  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for add; borrow-in (active-high) for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 S  output  WIDTH  result.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 ovf  output  1  two's-complement overflow of the operation.
REQ-014 out_valid  output  1  S/cout/ovf hold a valid result.
REQ-015 out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-016 Effective operation: {cout,S} = A + (B XOR {WIDTH{sub}}) + (cin XOR sub), modulo 2^(WIDTH+1).
REQ-017 Consequences: sub=0,cin=0 gives A+B; sub=1,cin=0 gives A-B with cout=1 meaning no borrow; sub=1,cin=1 gives A-B-1.
REQ-018 ovf = 1 when both effective operand MSBs are equal and the S MSB differs from them.
REQ-019 Stage k (0..NBLK-1) computes block k (bits BLOCK*k+BLOCK-1 : BLOCK*k) from its registered carry-in; stage 0 uses the effective cin.
REQ-020 Each stage forms both block sums (carry-in 0 and 1) and selects one with the incoming carry; ripple within a block only.
REQ-021 Each stage register holds valid bit, completed low sum bits, outgoing carry, and the not-yet-summed upper operand bits (B already inverted when sub=1).
REQ-022 Transfer occurs on a rising edge when in_valid && in_ready; the transfer loads stage 0.
REQ-023 Latency: a result accepted at edge t is presented with out_valid=1 after edge t+NBLK-1 (WIDTH=16, BLOCK=4: after the 4th edge counting the accept edge).
REQ-024 Stage NBLK-1 registers drive S, cout, ovf, out_valid directly; no combinational path from A/B to outputs.
REQ-025 Stage k advances when its successor is empty or advancing; the last stage advances when !out_valid || out_ready.
REQ-026 in_ready = stage 0 advance condition; it may depend combinationally on out_ready.
REQ-027 With out_ready held 1, throughput is one operation per cycle and in_ready stays 1.
REQ-028 While out_valid && !out_ready: S, cout, ovf held stable; upstream bubbles collapse; once all stages are full, in_ready = 0.
REQ-029 Results leave in acceptance order; none dropped or duplicated.
REQ-030 Simultaneous accept at stage 0 and output handshake in the same cycle is legal and loses nothing.
REQ-031 NBLK = 1 degenerates to a single registered adder with latency 1.
REQ-032 WIDTH not a multiple of BLOCK, or BLOCK < 1, or BLOCK > WIDTH, is a configuration error flagged at elaboration.

Reset
REQ-033 While rst_n = 0: all stage valid bits, out_valid, S, cout and ovf are 0, asynchronously, without clk.
REQ-034 in_ready is 1 during and after reset.
REQ-035 Reset asserted mid-operation discards all in-flight operations; none appear after release.
REQ-036 First transfer is possible on the first rising edge with rst_n = 1.

Verification (WIDTH=16, BLOCK=4 unless stated)
REQ-037 Add: A=0xFFFF, B=0x0001, cin=0, sub=0 -> S=0x0000, cout=1, ovf=0, out_valid 4 edges after accept.
REQ-038 Subtract/overflow: A=0x8000, B=0x0001, sub=1, cin=0 -> S=0x7FFF, cout=1, ovf=1; A=0x0003, B=0x0005, sub=1 -> S=0xFFFE, cout=0, ovf=0.
REQ-039 Streaming: 100 random back-to-back ops with out_ready=1 -> in_ready constant 1, results in order, all match REQ-016.
REQ-040 Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> exactly 4 accepted, then in_ready=0, S held; releasing out_ready drains all in order.
REQ-041 Reset: rst_n low with 3 ops in flight -> out_valid=0 immediately; no stale results after release.
REQ-042 Parameter sweep: WIDTH=8/BLOCK=8, WIDTH=32/BLOCK=4, WIDTH=12/BLOCK=3 -> latency NBLK and exhaustive/random match with REQ-016 and REQ-018.
